// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported byte-wide memory between a 32-bit instruction fetcher
// (four sequential byte reads) and a byte load/store port.
module mem_port_arbiter #(
    parameter int PRIO = 0,
    parameter int AW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_valid,
    output logic [31:0]   if_data,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [7:0]    d_wdata,
    output logic [7:0]    d_rdata,
    output logic          d_done,
    output logic [AW-1:0] m_addr,
    output logic [7:0]    m_wdata,
    output logic          m_wen,
    input  logic [7:0]    m_rdata,
    output logic          busy
);

    typedef enum logic [3:0] {
        IDLE, F0, F1, F2, F3, FCAP, FCPL, DRD, DCAP, DWR, DCPL
    } state_t;

    typedef enum logic {
        GNT_FETCH,
        GNT_DATA
    } grant_t;

    state_t      state;
    grant_t      last_grant;
    logic [23:0] fetch_buf;
    logic        grant_d;
    logic        grant_f;

    // Data wins when alone, under fixed priority, or when fetch had the last turn.
    always_comb begin
        grant_d = d_req && (!if_req || (PRIO != 0) || (last_grant == GNT_FETCH));
        grant_f = if_req && !grant_d;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= GNT_FETCH;
            fetch_buf  <= '0;
            if_valid   <= 1'b0;
            if_data    <= '0;
            d_rdata    <= '0;
            d_done     <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            m_wen      <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_done   <= 1'b0;
            m_wen    <= 1'b0;
            case (state)
                IDLE: begin
                    // m_addr/m_wdata double as the latched request fields.
                    if (grant_d) begin
                        last_grant <= GNT_DATA;
                        m_addr     <= d_addr;
                        if (d_we) begin
                            m_wdata <= d_wdata;
                            m_wen   <= 1'b1;
                            state   <= DWR;
                        end else begin
                            state <= DRD;
                        end
                    end else if (grant_f) begin
                        last_grant <= GNT_FETCH;
                        m_addr     <= if_addr;
                        state      <= F0;
                    end
                end
                F0: begin
                    m_addr <= m_addr + AW'(1);
                    state  <= F1;
                end
                F1: begin
                    m_addr          <= m_addr + AW'(1);
                    fetch_buf[7:0]  <= m_rdata;
                    state           <= F2;
                end
                F2: begin
                    m_addr          <= m_addr + AW'(1);
                    fetch_buf[15:8] <= m_rdata;
                    state           <= F3;
                end
                F3: begin
                    fetch_buf[23:16] <= m_rdata;
                    state            <= FCAP;
                end
                FCAP: begin
                    if_data  <= {m_rdata, fetch_buf};
                    if_valid <= 1'b1;
                    state    <= FCPL;
                end
                FCPL:    state <= IDLE;
                DRD:     state <= DCAP;
                DCAP: begin
                    d_rdata <= m_rdata;
                    d_done  <= 1'b1;
                    state   <= DCPL;
                end
                DWR: begin
                    d_done <= 1'b1;
                    state  <= DCPL;
                end
                DCPL:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported 8-bit external memory between the core's instruction-fetch requester and its load/store requester. Instruction fetches are 32-bit words, assembled from four sequential byte reads. Data accesses are single-byte reads or writes. The block sits between the mips core and exmemory and owns every memory-side address, data and write-enable signal.

Parameters:
PRIO, 0, arbitration mode: 0 = round-robin, 1 = data requester has fixed priority.
AW, 8, address width in bits. Byte addresses wrap modulo 2^AW.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous, active-high reset
if_req  input  1  fetch request; level, held until if_valid
if_addr  input  AW  fetch byte address; need not be word-aligned
if_valid  output  1  one-cycle pulse: if_data holds the completed word
if_data  output  32  fetched word, little-endian; held until the next fetch completes
d_req  input  1  data request; level, held until d_done
d_we  input  1  1 = write, 0 = read
d_addr  input  AW  data byte address
d_wdata  input  8  write data
d_rdata  output  8  read data; held until the next data read completes
d_done  output  1  one-cycle completion pulse for reads and writes
m_addr  output  AW  memory address
m_wdata  output  8  memory write data
m_wen  output  1  memory write enable
m_rdata  input  8  memory read data; valid in the cycle after m_addr is presented
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (rst=1 at a rising edge):
  - State goes to IDLE; any in-flight transaction is dropped without a completion pulse.
  - if_valid, d_done, m_wen, busy = 0.
  - if_data, d_rdata, m_addr, m_wdata = 0.
  - Round-robin pointer last_grant = FETCH, so data wins the first tie.
- States: IDLE, F0, F1, F2, F3, FCAP, FCPL, DRD, DCAP, DWR, DCPL. All outputs are registered or decoded from the state register; no input-to-output combinational paths except m_rdata capture.
- IDLE, cycle T: request arbitration.
  - Only d_req: go to DRD or DWR, selected by d_we.
  - Only if_req: go to F0.
  - Both with PRIO=1: data wins.
  - Both with PRIO=0: grant the requester not equal to last_grant.
  - last_grant updates on every grant.
  - The granted request's address, we and wdata are latched at end of T; later changes to those inputs are ignored until completion.
- Fetch timing:
  - F0..F3 (cycles T+1..T+4): m_addr = latched if_addr + k, modulo 2^AW; m_wen = 0.
  - m_rdata is captured at the end of T+2..T+5 into byte lanes [7:0], [15:8], [23:16], [31:24].
  - FCAP (T+5): capture the last byte.
  - FCPL (T+6): if_valid = 1 and if_data is updated; next state IDLE.
  - Latency from the accepting IDLE cycle to if_valid is 6 cycles.
- Data read timing:
  - DRD (T+1): m_addr = d_addr, m_wen = 0.
  - DCAP (T+2): capture m_rdata.
  - DCPL (T+3): d_done = 1, d_rdata is updated.
- Data write timing:
  - DWR (T+1): m_addr = d_addr, m_wdata = d_wdata, m_wen = 1 for exactly this cycle.
  - DCPL (T+2): d_done = 1; d_rdata is unchanged.
- Completion and re-grant:
  - A requester drops req in the cycle after its completion pulse.
  - The completion cycle is not IDLE, so a still-high req is never double-granted in that cycle.
  - The earliest next grant is the IDLE cycle after FCPL/DCPL.
- m_wen is 0 in every state except DWR.
- m_addr and m_wdata hold their last value while IDLE.
- A request that arrives while busy waits, with no loss and no timeout.
- if_valid and d_done are never high in the same cycle.

Test Plan:
- Reset: hold rst for 2 cycles with if_req=d_req=1. Required: all outputs 0 during reset; the first grant after reset goes to data.
- Fetch: preload mem[0x10..0x13] = 11,22,33,44; pulse if_req with if_addr=0x10 and d_req=0. Required: m_addr steps 10,11,12,13 on T+1..T+4; if_valid pulses at T+6 with if_data=0x44332211; m_wen stays 0.
- Wrap: fetch at if_addr=0xFE. Required: m_addr sequence FE, FF, 00, 01; if_data assembles bytes in that order.
- Write then read: d_we=1, d_addr=0xFF, d_wdata=13 gives m_wen=1 only at T+1 and d_done at T+2. A following read of 0xFF gives d_done 3 cycles after grant with d_rdata=13.
- Contention with PRIO=0, both requesters held continuously: grants alternate data, fetch, data, fetch. With PRIO=1, data is granted every time it requests.
- Mid-operation reset: assert rst in F2. Required: next cycle is IDLE with busy=0; no if_valid pulse; if_data=0.
